// File: rtl/alu_sequencer.sv
// Initiator side of the CHIP-8 ALU request/done handshake for 8XY4 and 7XNN.
// Fetches operands, holds the ALU request until done, then writes back VX and VF.
package structs;
    typedef enum logic [2:0] {ADD, SUB, SUBN, BOR, BAND, BXOR, SHR, SHL} alu_op;

    typedef struct packed {
        alu_op      op;
        logic [7:0] operand_a;
        logic [7:0] operand_b;
    } alu_input;
endpackage

module alu_sequencer
    import structs::*;
#(
    parameter int DONE_TIMEOUT = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  rd_addr_a,
    output logic [3:0]  rd_addr_b,
    input  logic [7:0]  rd_data_a,
    input  logic [7:0]  rd_data_b,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        alu_rst,
    output alu_input    alu_req,
    input  logic [7:0]  alu_result,
    input  logic        alu_overflow,
    input  logic        alu_done
);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WB_RES, WB_FLAG, FIN} state_t;

    state_t        state_q, state_d;
    logic [15:0]   op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          ovf_q, ovf_d;
    logic          err_flag_q, err_flag_d;
    alu_input      req_d;
    logic [3:0]    rd_a_d, rd_b_d, wr_addr_d;
    logic [7:0]    wr_data_d;
    logic          start_legal, op_is_8xy4;

    assign start_legal = (opcode[15:12] == 4'h7) ||
                         ((opcode[15:12] == 4'h8) && (opcode[3:0] == 4'h4));
    // Only legal opcodes get past IDLE, so the top nibble alone separates 8XY4 from 7XNN.
    assign op_is_8xy4  = (op_q[15:12] == 4'h8);
    assign cnt_inc     = cnt_q + CW'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        err_flag_d = err_flag_q;
        req_d      = alu_req;
        rd_a_d     = rd_addr_a;
        rd_b_d     = rd_addr_b;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = opcode;
                    if (start_legal) begin
                        err_flag_d = 1'b0;
                        rd_a_d     = opcode[11:8];
                        rd_b_d     = opcode[7:4];
                        state_d    = READ;
                    end else begin
                        err_flag_d = 1'b1;
                        state_d    = FIN;
                    end
                end
            end
            READ: begin
                req_d.op        = ADD;
                req_d.operand_a = rd_data_a;
                req_d.operand_b = op_is_8xy4 ? rd_data_b : op_q[7:0];
                state_d         = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    ovf_d     = alu_overflow;
                    wr_addr_d = op_q[11:8];
                    wr_data_d = alu_result;
                    state_d   = WB_RES;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(DONE_TIMEOUT)) begin
                        err_flag_d = 1'b1;
                        state_d    = FIN;
                    end
                end
            end
            WB_RES: begin
                if (op_is_8xy4) begin
                    wr_addr_d = 4'hF;
                    wr_data_d = {7'b0, ovf_q};
                    state_d   = WB_FLAG;
                end else begin
                    state_d = FIN;
                end
            end
            WB_FLAG: state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            op_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            err_flag_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_addr_a  <= '0;
            rd_addr_b  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            alu_rst    <= 1'b1;
            alu_req    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            err_flag_q <= err_flag_d;
            busy       <= (state_d != IDLE);
            done       <= (state_d == FIN);
            err        <= (state_d == FIN) && err_flag_d;
            rd_addr_a  <= rd_a_d;
            rd_addr_b  <= rd_b_d;
            wr_en      <= (state_d == WB_RES) || (state_d == WB_FLAG);
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            alu_rst    <= !((state_d == ISSUE) || (state_d == WAIT));
            alu_req    <= req_d;
        end
    end
endmodule
